// File: rtl/commit_store_buffer.sv
// Commit store buffer: in-order FIFO of retired stores, drained one at a time to the
// data-memory bus with backoff on rejection, plus youngest-first load forwarding.
module commit_store_buffer #(
    parameter int unsigned SB_DEPTH    = 8,
    parameter int unsigned BACKOFF_CYC = 2,
    localparam int unsigned XLEN       = 32,
    localparam int unsigned CNT_W      = $clog2(SB_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             store_en,
    input  logic [XLEN-1:0]  store_addr,
    input  logic [XLEN-1:0]  store_data,
    input  logic [1:0]       store_size,
    output logic             store_ready,
    input  logic             bus_busy,
    output logic [1:0]       proc2Dmem_command,
    output logic [XLEN-1:0]  proc2Dmem_addr,
    output logic [XLEN-1:0]  proc2Dmem_data,
    output logic [1:0]       proc2Dmem_size,
    input  logic [3:0]       mem2proc_response,
    input  logic             ld_query,
    input  logic [XLEN-1:0]  ld_addr,
    input  logic [1:0]       ld_size,
    output logic             ld_fwd_hit,
    output logic [XLEN-1:0]  ld_fwd_data,
    output logic             ld_conflict,
    output logic             sb_empty,
    output logic [CNT_W-1:0] sb_count,
    output logic             overflow_err
);

    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned BO_W  = $clog2(BACKOFF_CYC + 1);
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic [1:0] {StIdle, StIssue, StBackoff} state_e;

    logic [SB_DEPTH-1:0] valid_q;
    logic [XLEN-1:0]     addr_q [SB_DEPTH];
    logic [XLEN-1:0]     data_q [SB_DEPTH];
    logic [1:0]          size_q [SB_DEPTH];
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [CNT_W-1:0]    count_q;
    logic                overflow_q;
    state_e              state_q;
    logic [BO_W-1:0]     backoff_q;

    logic push, issue_now, pop, reject;

    // Size encoding 3 is treated as a word since the bus is only XLEN wide.
    function automatic logic [3:0] size_bytes(input logic [1:0] s);
        unique case (s)
            2'd0:    size_bytes = 4'd1;
            2'd1:    size_bytes = 4'd2;
            default: size_bytes = 4'd4;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] s);
        unique case (s)
            2'd0:    size_mask = 32'h0000_00ff;
            2'd1:    size_mask = 32'h0000_ffff;
            default: size_mask = 32'hffff_ffff;
        endcase
    endfunction

    // Handshake decode: ready from registered count only, issue gated by bus ownership.
    always_comb begin
        store_ready       = (count_q != CNT_W'(SB_DEPTH));
        push              = store_en && store_ready;
        issue_now         = (state_q == StIssue) && !bus_busy;
        pop               = issue_now && (mem2proc_response != 4'd0);
        reject            = issue_now && (mem2proc_response == 4'd0);
        proc2Dmem_command = issue_now ? BUS_STORE : BUS_NONE;
        proc2Dmem_addr    = addr_q[head_q];
        proc2Dmem_data    = data_q[head_q];
        proc2Dmem_size    = size_q[head_q];
        sb_empty          = (count_q == '0) && (state_q == StIdle);
        sb_count          = count_q;
        overflow_err      = overflow_q;
    end

    // FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                size_q[i] <= '0;
            end
        end else begin
            if (store_en && !store_ready) overflow_q <= 1'b1;
            // Push and pop never target the same slot: that needs empty (no pop) or full (no push).
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= store_addr;
                data_q[tail_q]  <= store_data;
                size_q[tail_q]  <= store_size;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!push && pop) count_q <= count_q - CNT_W'(1);
        end
    end

    // Drain FSM: IDLE waits for work, ISSUE drives the head, BACKOFF idles after a reject.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            backoff_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (count_q != '0) state_q <= StIssue;
                end
                StIssue: begin
                    if (pop) begin
                        state_q <= ((count_q > CNT_W'(1)) || push) ? StIssue : StIdle;
                    end else if (reject) begin
                        state_q   <= StBackoff;
                        backoff_q <= BO_W'(BACKOFF_CYC);
                    end
                end
                StBackoff: begin
                    // Last non-issue cycle when the counter is at 1; it hits 0 as ISSUE resumes.
                    if (backoff_q <= BO_W'(1)) state_q <= StIssue;
                    if (backoff_q != '0) backoff_q <= backoff_q - BO_W'(1);
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [PTR_W-1:0] idx;
    logic [XLEN:0]    ld_lo, ld_hi, e_lo, e_hi;
    logic [4:0]       shamt;
    logic             found;

    // Forwarding: scan youngest to oldest, the first overlapping valid entry decides.
    always_comb begin
        ld_fwd_hit  = 1'b0;
        ld_fwd_data = '0;
        ld_conflict = 1'b0;
        found       = 1'b0;
        idx         = '0;
        e_lo        = '0;
        e_hi        = '0;
        shamt       = '0;
        ld_lo       = {1'b0, ld_addr};
        ld_hi       = ld_lo + (XLEN+1)'(size_bytes(ld_size));
        if (ld_query) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                idx  = tail_q - PTR_W'(i + 1);
                e_lo = {1'b0, addr_q[idx]};
                e_hi = e_lo + (XLEN+1)'(size_bytes(size_q[idx]));
                if (!found && valid_q[idx] && (ld_lo < e_hi) && (e_lo < ld_hi)) begin
                    found = 1'b1;
                    if ((e_lo <= ld_lo) && (ld_hi <= e_hi)) begin
                        shamt       = {ld_addr[1:0] - addr_q[idx][1:0], 3'b000};
                        ld_fwd_hit  = 1'b1;
                        ld_fwd_data = (data_q[idx] >> shamt) & size_mask(ld_size);
                    end else begin
                        ld_conflict = 1'b1;
                    end
                end
            end
        end
    end

endmodule
